// File: rtl/sdft_pkg.sv
// Shared types for the SDFT peak-finder slice: frequency-domain word, peak result and FSM states.
`timescale 1ns/1ps
package sdft_pkg;

    localparam int SDFT_N   = 4096;
    localparam int SDFT_IDW = 32;
    localparam int SDFT_AW  = $clog2(SDFT_N);
    localparam int SDFT_PW  = 2*SDFT_IDW + 1;

    // "real" is a reserved word, so the components are re/im.
    typedef struct packed {
        logic signed [SDFT_IDW-1:0] im;
        logic signed [SDFT_IDW-1:0] re;
    } fd_word_t;

    typedef struct packed {
        logic [SDFT_AW-1:0] idx;
        logic [SDFT_PW-1:0] pow;
    } peak_res_t;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } peak_state_t;

endpackage

// File: rtl/power_sq2.sv
// Two-stage registered re^2 + im^2 power pipeline with a sideband that travels alongside the data.
`timescale 1ns/1ps
module power_sq2
    import sdft_pkg::*;
#(
    parameter int IDW = SDFT_IDW,
    parameter int SBW = 1,
    parameter int PW  = 2*IDW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic signed [IDW-1:0] re,
    input  logic signed [IDW-1:0] im,
    input  logic [SBW-1:0]        side,
    output logic                  pow_valid,
    output logic [PW-1:0]         pow,
    output logic [SBW-1:0]        pow_side
);

    // Squares of a signed IDW value always fit the 2*IDW-bit product, even for the most negative input.
    logic signed [2*IDW-1:0] re_ext;
    logic signed [2*IDW-1:0] im_ext;
    logic        [2*IDW-1:0] sq_re;
    logic        [2*IDW-1:0] sq_im;
    logic                    s1_valid;
    logic        [SBW-1:0]   s1_side;

    assign re_ext = {{IDW{re[IDW-1]}}, re};
    assign im_ext = {{IDW{im[IDW-1]}}, im};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_side   <= '0;
            sq_re     <= '0;
            sq_im     <= '0;
            pow_valid <= 1'b0;
            pow_side  <= '0;
            pow       <= '0;
        end else begin
            s1_valid  <= valid;
            pow_valid <= s1_valid;
            if (valid) begin
                sq_re   <= re_ext * re_ext;
                sq_im   <= im_ext * im_ext;
                s1_side <= side;
            end
            if (s1_valid) begin
                pow      <= {1'b0, sq_re} + {1'b0, sq_im};
                pow_side <= s1_side;
            end
        end
    end

endmodule

// File: rtl/sdft_peak_finder.sv
// Per-block peak-power search over the SDFT output stream with framing checks and a valid/ready result.
// Optional: define SDFT_PEAK_SKIP_DC_EN to exclude bin 0 from the search.
`timescale 1ns/1ps
module sdft_peak_finder
    import sdft_pkg::*;
#(
    parameter int N   = SDFT_N,
    parameter int IDW = SDFT_IDW,
    parameter int AW  = $clog2(N),
    parameter int PW  = 2*IDW + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [2*IDW-1:0]  data_i,
    input  logic              sob_i,
    input  logic              eob_i,
    input  logic              valid_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [AW-1:0]     res_idx_o,
    output logic [PW-1:0]     res_pow_o,
    output logic              overrun_o,
    output logic              frame_err_o
);

    localparam int SBW = AW + 3;

    logic [AW-1:0]  cur_idx;
    logic [AW-1:0]  beat_idx;
    logic           beat_wrap;
    logic           s2_valid;
    logic [PW-1:0]  s2_pow;
    logic [SBW-1:0] s2_side;
    logic           s2_wrap;
    logic           s2_sob;
    logic           s2_eob;
    logic [AW-1:0]  s2_idx;
    logic [PW-1:0]  first_pow;
    logic [PW-1:0]  max_pow;
    logic [AW-1:0]  max_idx;
    peak_state_t    state;

    // A beat past bin N-1 is tagged so the FSM can reject the overlong block when it arrives.
    always_comb begin
        beat_wrap = 1'b0;
        beat_idx  = cur_idx + 1'b1;
        if (sob_i) begin
            beat_idx = '0;
        end else if (cur_idx == AW'(N-1)) begin
            beat_idx  = '0;
            beat_wrap = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cur_idx <= '0;
        end else if (valid_i) begin
            cur_idx <= beat_idx;
        end
    end

    power_sq2 #(
        .IDW (IDW),
        .SBW (SBW),
        .PW  (PW)
    ) u_power (
        .clk       (clk_i),
        .rst       (rst_i),
        .valid     (valid_i),
        .re        (data_i[IDW-1:0]),
        .im        (data_i[2*IDW-1:IDW]),
        .side      ({beat_wrap, sob_i, eob_i, beat_idx}),
        .pow_valid (s2_valid),
        .pow       (s2_pow),
        .pow_side  (s2_side)
    );

    assign {s2_wrap, s2_sob, s2_eob, s2_idx} = s2_side;

`ifdef SDFT_PEAK_SKIP_DC_EN
    assign first_pow = '0;
`else
    assign first_pow = s2_pow;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            max_pow     <= '0;
            max_idx     <= '0;
            res_valid_o <= 1'b0;
            res_idx_o   <= '0;
            res_pow_o   <= '0;
            overrun_o   <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            overrun_o   <= 1'b0;
            frame_err_o <= 1'b0;
            if (res_valid_o && res_ready_i) begin
                res_valid_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (s2_valid && s2_sob) begin
                        max_pow <= first_pow;
                        max_idx <= '0;
                        state   <= s2_eob ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (s2_valid) begin
                        if (s2_sob) begin
                            frame_err_o <= 1'b1;
                            max_pow     <= first_pow;
                            max_idx     <= '0;
                            state       <= s2_eob ? DONE : ACC;
                        end else if (s2_wrap) begin
                            frame_err_o <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            // Strict compare keeps the lowest index on ties.
                            if (s2_pow > max_pow) begin
                                max_pow <= s2_pow;
                                max_idx <= s2_idx;
                            end
                            if (s2_eob) begin
                                state <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    res_valid_o <= 1'b1;
                    res_idx_o   <= max_idx;
                    res_pow_o   <= max_pow;
                    overrun_o   <= res_valid_o && !res_ready_i;
                    if (s2_valid && s2_sob) begin
                        max_pow <= first_pow;
                        max_idx <= '0;
                        state   <= s2_eob ? DONE : ACC;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdft_peak_finder.sv
// Directed, table-driven bench for sdft_peak_finder at N=8; honours SDFT_PEAK_SKIP_DC_EN in its expectations.
`timescale 1ns/1ps
module tb_sdft_peak_finder;

    localparam int N   = 8;
    localparam int IDW = 32;
    localparam int AW  = 3;
    localparam int PW  = 65;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [2*IDW-1:0] data_i;
    logic             sob_i;
    logic             eob_i;
    logic             valid_i;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [AW-1:0]    res_idx_o;
    logic [PW-1:0]    res_pow_o;
    logic             overrun_o;
    logic             frame_err_o;

    sdft_peak_finder #(
        .N   (N),
        .IDW (IDW),
        .AW  (AW),
        .PW  (PW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .sob_i       (sob_i),
        .eob_i       (eob_i),
        .valid_i     (valid_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_idx_o   (res_idx_o),
        .res_pow_o   (res_pow_o),
        .overrun_o   (overrun_o),
        .frame_err_o (frame_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int               len;
        int               gap;
        logic [7:0][31:0] re;
        logic [7:0][31:0] im;
        int               exp_idx;
        logic [64:0]      exp_pow;
    } vec_t;

    vec_t vecs[6];

    int   pass_cnt    = 0;
    int   check_cnt   = 0;
    int   overrun_cnt = 0;
    int   ferr_cnt    = 0;
    int   accept_cnt  = 0;
    int   rise_cnt    = 0;
    logic prev_valid  = 1'b0;

    always @(negedge clk) begin
        if (overrun_o) overrun_cnt++;
        if (frame_err_o) ferr_cnt++;
        if (res_valid_o && res_ready_i) accept_cnt++;
        if (res_valid_o && !prev_valid) rise_cnt++;
        prev_valid = res_valid_o;
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        check_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic [31:0] re, input logic [31:0] im, input logic sob, input logic eob);
        @(negedge clk);
        data_i  = {im, re};
        sob_i   = sob;
        eob_i   = eob;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        sob_i   = 1'b0;
        eob_i   = 1'b0;
    endtask

    task automatic sendBlock(input vec_t v);
        for (int i = 0; i < v.len; i++) begin
            applyStimulus(v.re[i], v.im[i], i == 0, i == v.len - 1);
            if (i != v.len - 1) repeat (v.gap) @(posedge clk);
        end
    endtask

    // Counts edges after the eob-sampling edge until res_valid_o is seen; capped at 20.
    task automatic waitResult(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!res_valid_o && cycles < 20);
    endtask

    int cyc;
    int base_ovr;
    int base_acc;
    int base_ferr;
    int base_rise;

    initial begin
        for (int k = 0; k < 6; k++) vecs[k] = '0;
        vecs[0].len = 8;
        vecs[0].re[1] = 1;  vecs[0].re[2] = 2;  vecs[0].re[3] = 3;  vecs[0].re[4] = 10;
        vecs[0].re[5] = 3;  vecs[0].re[6] = 2;  vecs[0].re[7] = 1;
        vecs[0].exp_idx = 4; vecs[0].exp_pow = 65'd100;
        vecs[1].len = 8;
        vecs[1].re[2] = 5;  vecs[1].re[6] = 5;
        vecs[1].exp_idx = 2; vecs[1].exp_pow = 65'd25;
        vecs[2].len = 8;
        vecs[2].re[3] = -32'sd7; vecs[2].im[3] = 32'sd7;
        vecs[2].re[5] = 9;       vecs[2].im[5] = -32'sd3;
        vecs[2].exp_idx = 3; vecs[2].exp_pow = 65'd98;
        vecs[3].len = 1;
        vecs[3].re[0] = 32'h8000_0000; vecs[3].im[0] = 32'h8000_0000;
        vecs[4].len = 8;
        vecs[4].re[0] = 1000; vecs[4].re[5] = 3;
        vecs[5].len = 4; vecs[5].gap = 2;
        vecs[5].re[1] = 1; vecs[5].re[2] = 4; vecs[5].im[3] = -32'sd4;
        vecs[5].exp_idx = 2; vecs[5].exp_pow = 65'd16;
`ifdef SDFT_PEAK_SKIP_DC_EN
        vecs[3].exp_idx = 0; vecs[3].exp_pow = 65'd0;
        vecs[4].exp_idx = 5; vecs[4].exp_pow = 65'd9;
`else
        vecs[3].exp_idx = 0; vecs[3].exp_pow = 65'h0_8000_0000_0000_0000;
        vecs[4].exp_idx = 0; vecs[4].exp_pow = 65'd1000000;
`endif

        rst_i = 1'b1; data_i = '0; sob_i = 1'b0; eob_i = 1'b0; valid_i = 1'b0; res_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset res_valid", res_valid_o, 0);
        checkOutput("reset res_idx", res_idx_o, 0);
        checkOutput("reset res_pow", res_pow_o, 0);
        checkOutput("reset pulses", {overrun_o, frame_err_o}, 0);
        rst_i = 1'b0;
        res_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < 6; k++) begin
            sendBlock(vecs[k]);
            waitResult(cyc);
            checkOutput($sformatf("vec%0d latency", k), cyc, 3);
            checkOutput($sformatf("vec%0d idx", k), res_idx_o, vecs[k].exp_idx);
            checkOutput($sformatf("vec%0d pow", k), res_pow_o, vecs[k].exp_pow);
            repeat (2) @(posedge clk);
            #1;
        end

        // Back-to-back blocks with nobody accepting: second result overwrites the first.
        res_ready_i = 1'b0;
        base_ovr  = overrun_cnt;
        base_rise = rise_cnt;
        for (int i = 0; i < 8; i++) applyStimulus((i == 1) ? 32'd20 : 32'd1, 32'd0, i == 0, i == 7);
        for (int i = 0; i < 8; i++) applyStimulus((i == 5) ? -32'sd30 : 32'sd2, 32'd0, i == 0, i == 7);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("overrun pulses", overrun_cnt - base_ovr, 1);
        checkOutput("overrun single rise", rise_cnt - base_rise, 1);
        checkOutput("overrun idx", res_idx_o, 5);
        checkOutput("overrun pow", res_pow_o, 900);
        base_acc = accept_cnt;
        res_ready_i = 1'b1;
        @(posedge clk);
        #1;
        res_ready_i = 1'b0;
        checkOutput("accept drops valid", res_valid_o, 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("accept count", accept_cnt - base_acc, 1);
        checkOutput("valid stays low", res_valid_o, 0);

        // A sob inside an open block restarts it; then an overlong block is rejected.
        res_ready_i = 1'b1;
        base_ferr = ferr_cnt;
        applyStimulus(0, 0, 1'b1, 1'b0);
        applyStimulus(1, 0, 1'b0, 1'b0);
        applyStimulus(2, 0, 1'b0, 1'b0);
        applyStimulus(0, 0, 1'b1, 1'b0);
        applyStimulus(1, 0, 1'b0, 1'b0);
        applyStimulus(6, 0, 1'b0, 1'b0);
        applyStimulus(2, 0, 1'b0, 1'b1);
        waitResult(cyc);
        checkOutput("restart latency", cyc, 3);
        checkOutput("restart idx", res_idx_o, 2);
        checkOutput("restart pow", res_pow_o, 36);
        checkOutput("restart frame_err", ferr_cnt - base_ferr, 1);
        repeat (2) @(posedge clk);
        #1;
        base_ferr = ferr_cnt;
        base_rise = rise_cnt;
        for (int i = 0; i < 9; i++) applyStimulus(i + 1, 0, i == 0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("overlong frame_err", ferr_cnt - base_ferr, 1);
        checkOutput("overlong no result", rise_cnt - base_rise, 0);

        // Reset between clock edges, mid-block, while a result is being held.
        res_ready_i = 1'b0;
        sendBlock(vecs[0]);
        waitResult(cyc);
        checkOutput("held idx before reset", res_idx_o, 4);
        base_ferr = ferr_cnt;
        applyStimulus(0, 0, 1'b1, 1'b0);
        applyStimulus(50, 0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst_i = 1'b1;
        #1;
        checkOutput("async reset valid", res_valid_o, 0);
        checkOutput("async reset idx", res_idx_o, 0);
        checkOutput("async reset pow", res_pow_o, 0);
        checkOutput("async reset pulses", {overrun_o, frame_err_o}, 0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        res_ready_i = 1'b1;
        sendBlock(vecs[1]);
        waitResult(cyc);
        checkOutput("post-reset latency", cyc, 3);
        checkOutput("post-reset idx", res_idx_o, 2);
        checkOutput("post-reset pow", res_pow_o, 25);
        checkOutput("post-reset no frame_err", ferr_cnt - base_ferr, 0);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
